// File: rtl/aes_inv_shift_rows_stage.sv
// ----------------------------------------------------------------------------
// aes_inv_shift_rows_stage
//
// Registered InvShiftRows stage for the AES decryption datapath. It sits
// between AddRoundKey and InvSubBytes in the decrypt round. The byte
// permutation is applied when a block is captured, so both storage registers
// already hold permuted state. A 2-entry elastic (skid) buffer gives full
// throughput, and in_ready is driven only from a register.
//
// Byte k of a 128-bit state is bits [8k+7:8k].
//   Inverse map : out byte k = in byte IMAP[k],
//                 IMAP = 12,9,6,3,0,13,10,7,4,1,14,11,8,5,2,15
//   Forward map : FMAP = 4,9,14,3,8,13,2,7,12,1,6,11,0,5,10,15
//
// Optional feature macro: AES_ISR_DIR_SEL_EN
//   defined   : adds input in_fwd, which is captured with each block
//               (1 = FMAP / forward ShiftRows, 0 = IMAP). One stage can then
//               serve both encryption and decryption.
//   undefined : there is no in_fwd port and IMAP is always applied.
//
// Parameters
//   TAG_W      width of the sideband tag carried with each block (>= 1)
//
// Ports
//   clk        clock; all logic runs on the rising edge
//   rst        synchronous reset, active-high; has priority over flush
//   flush      synchronous clear of all buffered blocks
//   in_valid   input block valid
//   in_ready   stage can accept a block this cycle (registered)
//   in_block   input state
//   in_tag     input sideband tag
//   in_fwd     direction select (only with AES_ISR_DIR_SEL_EN)
//   out_valid  output block valid
//   out_ready  downstream accepts the output block
//   out_block  permuted state
//   out_tag    tag that belongs to out_block
//   occupancy  number of buffered blocks (0..2)
// ----------------------------------------------------------------------------
module aes_inv_shift_rows_stage #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    input  logic [TAG_W-1:0] in_tag,
`ifdef AES_ISR_DIR_SEL_EN
    input  logic             in_fwd,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);

    // The encoding equals the number of buffered blocks.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Source byte index for each output byte. Nibble k holds the map entry
    // for output byte k, with byte 0 in the least significant nibble.
    localparam logic [63:0] IMAP_P = 64'hF258_BE14_7AD0_369C;
    localparam logic [63:0] FMAP_P = 64'hFA50_B61C_72D8_3E94;

    function automatic logic [127:0] permute(input logic [127:0] blk,
                                             input logic         fwd);
        logic [63:0]  map;
        logic [3:0]   src;
        logic [127:0] res;
        map = fwd ? FMAP_P : IMAP_P;
        res = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            src = map[{k[3:0], 2'b00} +: 4];
            res[{k[3:0], 3'b000} +: 8] = blk[{src, 3'b000} +: 8];
        end
        return res;
    endfunction

    state_e             state_q,    state_d;
    logic [127:0]       main_blk_q, main_blk_d;
    logic [TAG_W-1:0]   main_tag_q, main_tag_d;
    logic [127:0]       skid_blk_q, skid_blk_d;
    logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
    logic               in_ready_q, in_ready_d;

    logic               dir_fwd;
    logic [127:0]       perm_blk;
    logic               accept;
    logic               emit;

`ifdef AES_ISR_DIR_SEL_EN
    assign dir_fwd = in_fwd;
`else
    assign dir_fwd = 1'b0;
`endif

    assign perm_blk  = permute(in_block, dir_fwd);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_blk_d = main_blk_q;
        main_tag_d = main_tag_q;
        skid_blk_d = skid_blk_q;
        skid_tag_d = skid_tag_q;

        if (flush) begin
            // A block presented in the flush cycle is dropped along with the
            // buffered ones; the data registers keep stale contents, which are
            // hidden because out_valid is low.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_blk_d = perm_blk;
                        main_tag_d = in_tag;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_blk_d = perm_blk;
                        main_tag_d = in_tag;
                    end else if (accept) begin
                        skid_blk_d = perm_blk;
                        skid_tag_d = in_tag;
                        state_d    = ST_FULL;
                    end else if (emit) begin
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no accept can happen.
                    if (emit) begin
                        main_blk_d = skid_blk_q;
                        main_tag_d = skid_tag_q;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Registered ready: this is computed from the next state, so there is
        // no combinational path from out_ready to in_ready.
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_blk_q <= '0;
            main_tag_q <= '0;
            skid_blk_q <= '0;
            skid_tag_q <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_blk_q <= main_blk_d;
            main_tag_q <= main_tag_d;
            skid_blk_q <= skid_blk_d;
            skid_tag_q <= skid_tag_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_block = main_blk_q;
    assign out_tag   = main_tag_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_aes_inv_shift_rows_stage.sv
// ----------------------------------------------------------------------------
// tb_aes_inv_shift_rows_stage
//
// Directed bench for aes_inv_shift_rows_stage. Inputs change 1 time unit
// after each rising edge, and outputs are sampled at that same point.
// AES_ISR_DIR_SEL_EN must match the setting used for the RTL build.
// ----------------------------------------------------------------------------
module tb_aes_inv_shift_rows_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [3:0]   in_tag;
`ifdef AES_ISR_DIR_SEL_EN
    logic         in_fwd;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic [3:0]   out_tag;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] blk;
        logic [3:0]   tag;
    } item_t;

    always #5 clk = ~clk;

    aes_inv_shift_rows_stage #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_tag    (in_tag),
`ifdef AES_ISR_DIR_SEL_EN
        .in_fwd    (in_fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    // Reference maps taken directly from the byte tables.
    function automatic logic [127:0] tb_fwd(input logic [127:0] x);
        int fm[16] = '{4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11, 0, 5, 10, 15};
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = x[8*fm[k] +: 8];
        return r;
    endfunction

    function automatic logic [127:0] tb_inv(input logic [127:0] x);
        int im[16] = '{12, 9, 6, 3, 0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15};
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = x[8*im[k] +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
`ifdef AES_ISR_DIR_SEL_EN
        in_fwd    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%0b ready=%0b occ=%0d, want 0 1 0",
                     out_valid, in_ready, occupancy);
        end
        checks++;
        if ({out_block, out_tag} !== 132'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h, want 0/0", out_block, out_tag);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_block  = 128'h0f0e0d0c0b0a09080706050403020100;
        in_tag    = 4'd3;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_block !== 128'h0f0205080b0e0104070a0d000306090c ||
            out_tag !== 4'd3) begin
            errors++;
            $display("FAIL basic_vector: got v=%0b %h tag=%0d, want 1 0f0205080b0e0104070a0d000306090c 3",
                     out_valid, out_block, out_tag);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL basic_drain: got v=%0b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_round_trip();
        item_t        sb[$];
        item_t        exp;
        logic [127:0] x;
        int           sent;
        int           got;
        int           cyc;
        bit           acc;
        apply_reset();
        sent = 0;
        got  = 0;
        cyc  = 0;
        x    = '0;
        while (got < 1000 && cyc < 20000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                x        = {$urandom, $urandom, $urandom, $urandom};
                in_block = tb_fwd(x);
                in_tag   = sent[3:0];
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_valid && in_ready;
            if (acc) begin
                sb.push_back('{blk: x, tag: in_tag});
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rt_spurious: got %h with no block pending", out_block);
                end else begin
                    exp = sb.pop_front();
                    if ({out_block, out_tag} !== {exp.blk, exp.tag}) begin
                        errors++;
                        $display("FAIL rt_block%0d: got %h/%h, want %h/%h",
                                 got, out_block, out_tag, exp.blk, exp.tag);
                    end
                end
                got++;
            end
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 1000 || sb.size() != 0) begin
            errors++;
            $display("FAIL rt_count: got %0d outputs (%0d pending), want 1000 (0)",
                     got, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b, c;
        a = 128'h00112233445566778899aabbccddeeff;
        b = 128'hdeadbeef0123456789abcdeffedcba98;
        c = 128'h55aa55aa0f0f0f0f1234123412341234;
        apply_reset();
        in_valid = 1'b1; in_block = a; in_tag = 4'd1;
        tick();
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_block !== tb_inv(a)) begin
            errors++;
            $display("FAIL b2b_a: got occ=%0d rdy=%0b %h, want 1 1 %h",
                     occupancy, in_ready, out_block, tb_inv(a));
        end
        in_block = b; in_tag = 4'd2;
        tick();
        in_block = c; in_tag = 4'd3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_block !== tb_inv(a) || out_tag !== 4'd1) begin
                errors++;
                $display("FAIL b2b_full%0d: got occ=%0d rdy=%0b v=%0b %h/%h, want 2 0 1 %h/1",
                         i, occupancy, in_ready, out_valid, out_block, out_tag, tb_inv(a));
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_block !== tb_inv(b) || out_tag !== 4'd2 || occupancy !== 2'd1 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_b: got %h/%h occ=%0d rdy=%0b, want %h/2 1 1",
                     out_block, out_tag, occupancy, in_ready, tb_inv(b));
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_block !== tb_inv(c) || out_tag !== 4'd3 || out_valid !== 1'b1 ||
            occupancy !== 2'd1) begin
            errors++;
            $display("FAIL b2b_c: got %h/%h v=%0b occ=%0d, want %h/3 1 1",
                     out_block, out_tag, out_valid, occupancy, tb_inv(c));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL b2b_end: got v=%0b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_streaming();
        logic [127:0] v;
        int outs;
        apply_reset();
        out_ready = 1'b1;
        outs = 0;
        for (int i = 0; i <= 64; i++) begin
            if (i < 64) begin
                v        = {4{i[31:0] * 32'h01010101}};
                in_valid = 1'b1;
                in_block = v;
                in_tag   = i[3:0];
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                v = {4{(i - 1) * 32'h01010101}};
                checks++;
                if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_block !== tb_inv(v)) begin
                    errors++;
                    $display("FAIL stream%0d: got occ=%0d v=%0b %h, want 1 1 %h",
                             i, occupancy, out_valid, out_block, tb_inv(v));
                end
            end
            if (out_valid && out_ready) outs++;
            tick();
        end
        checks++;
        if (outs != 64 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs, v=%0b, want 64, 0", outs, out_valid);
        end
    endtask

    task automatic test_flush();
        int seen;
        logic [127:0] d;
        d = 128'hcafef00d_0badc0de_11223344_55667788;
        apply_reset();
        in_valid = 1'b1; in_block = 128'h1; in_tag = 4'd4;
        tick();
        in_block = 128'h2; in_tag = 4'd5;
        tick();
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL flush_fill: got occ=%0d, want 2", occupancy);
        end
        in_block = 128'h3; in_tag = 4'd6;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got v=%0b occ=%0d rdy=%0b, want 0 0 1",
                     out_valid, occupancy, in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_ghost: got %0d outputs after flush, want 0", seen);
        end
        in_valid = 1'b1; in_block = d; in_tag = 4'd7;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_block !== tb_inv(d) || out_tag !== 4'd7) begin
            errors++;
            $display("FAIL flush_next: got v=%0b %h/%h, want 1 %h/7",
                     out_valid, out_block, out_tag, tb_inv(d));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        apply_reset();
        in_valid = 1'b1; in_block = 128'hA; in_tag = 4'd9;
        tick();
        in_block = 128'hB; in_tag = 4'd10;
        tick();
        in_block = 128'hC; in_tag = 4'd11;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100 || {out_block, out_tag} !== 132'd0) begin
            errors++;
            $display("FAIL rst_mid: got v=%0b rdy=%0b occ=%0d %h/%h, want 0 1 0 0/0",
                     out_valid, in_ready, occupancy, out_block, out_tag);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_ghost: got %0d outputs after reset, want 0", seen);
        end
    endtask

`ifdef AES_ISR_DIR_SEL_EN
    task automatic test_dir_sel();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_block  = 128'h0f0e0d0c0b0a09080706050403020100;
        in_tag    = 4'd3;
        in_fwd    = 1'b1;
        tick();
        in_fwd = 1'b0;
        checks++;
        if (out_block !== 128'h0f0a05000b06010c07020d08030e0904 || out_tag !== 4'd3) begin
            errors++;
            $display("FAIL dir_fwd: got %h/%h, want 0f0a05000b06010c07020d08030e0904/3",
                     out_block, out_tag);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_block !== 128'h0f0205080b0e0104070a0d000306090c) begin
            errors++;
            $display("FAIL dir_inv: got %h, want 0f0205080b0e0104070a0d000306090c", out_block);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_round_trip();
        test_back_to_back();
        test_streaming();
        test_flush();
        test_reset_mid();
`ifdef AES_ISR_DIR_SEL_EN
        test_dir_sel();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
